// File: rtl/gpio_seg_pkg.sv
// Shared constants for the GPIO / 7-segment APB block: register offsets,
// the segment glyph table and the byte-strobe merge helper.
package gpio_seg_pkg;

    // Register index = paddr[4:2]
    localparam logic [2:0] REG_OUT    = 3'd0;
    localparam logic [2:0] REG_IN     = 3'd1;
    localparam logic [2:0] REG_SEG    = 3'd2;
    localparam logic [2:0] REG_SEGEN  = 3'd3;
    localparam logic [2:0] REG_IRQ_EN = 3'd4;
    localparam logic [2:0] REG_IRQ_ST = 3'd5;

    // Blank digit: every segment off (active-low)
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {a,b,c,d,e,f,g,dp} glyphs, indexed by hex nibble
    localparam logic [15:0][7:0] SEG7_LUT = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    // Replace only the strobed bytes of old_val with wdata
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] mask;
        mask = byte_mask(strb);
        return (old_val & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/gpio_seg_apb_if.sv
// APB3/APB4 peripheral bus bundle for the GPIO / 7-segment block.
interface gpio_seg_apb_if;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;

    modport slave (
        input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
        output in_pready, in_prdata, in_pslverr
    );

    modport master (
        output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
        input  in_pready, in_prdata, in_pslverr
    );
endinterface

// File: rtl/gpio_seg_scan.sv
// Time-multiplexed 7-segment scanner: prescaler, digit index, nibble select,
// glyph decode and per-digit blanking.
module gpio_seg_scan
    import gpio_seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] i_seg,
    input  logic [N_DIGITS-1:0]   i_segen,
    output logic [7:0]            o_seg_out,
    output logic [N_DIGITS-1:0]   o_seg_an
);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [PRE_W-1:0] r_pre;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       w_nibble;

    // Prescaler wraps every SCAN_DIV cycles and steps the digit index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_LAST) begin
            // NOTE: non-blocking so both counters update from pre-edge values
            r_pre <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Select the current digit's nibble, decode it or blank it
    always_comb begin
        w_nibble  = i_seg[{r_idx, 2'b00} +: 4];
        o_seg_out = i_segen[r_idx] ? SEG7_LUT[w_nibble] : SEG_BLANK;
        o_seg_an  = ~(N_DIGITS'(1) << r_idx);
    end
endmodule

// File: rtl/gpio_seg_apb.sv
// APB slave GPIO block: output bank, synchronised input bank with rising-edge
// interrupt capture, and a 7-segment display driven through gpio_seg_scan.
module gpio_seg_apb
    import gpio_seg_pkg::*;
#(
    parameter int N_OUT    = 16,
    parameter int N_IN     = 16,
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clock,
    input  logic                reset,
    gpio_seg_apb_if.slave       apb,
    output logic [N_OUT-1:0]    gpio_out,
    input  logic [N_IN-1:0]     gpio_in,
    output logic [7:0]          seg_out,
    output logic [N_DIGITS-1:0] seg_an,
    output logic                irq
);
    localparam int SEG_W = 4 * N_DIGITS;

    logic             w_access, w_mapped, w_wr, w_rd;
    logic [2:0]       w_reg;
    logic [31:0]      w_rdata;
    logic [N_IN-1:0]  w_rise, w_w1c;
    logic             w_unused;

    logic [N_OUT-1:0]    r_out;
    logic [SEG_W-1:0]    r_seg;
    logic [N_DIGITS-1:0] r_segen;
    logic [N_IN-1:0]     r_irq_en, r_irq_st;
    logic [N_IN-1:0]     r_sync1, r_sync2, r_sync_d;

    assign w_access = apb.in_psel & apb.in_penable;
    assign w_reg    = apb.in_paddr[4:2];
    assign w_mapped = (w_reg <= REG_IRQ_ST);
    assign w_wr     = w_access & apb.in_pwrite & w_mapped;
    assign w_rd     = w_access & ~apb.in_pwrite & w_mapped;
    assign w_rise   = r_sync2 & ~r_sync_d;
    assign w_w1c    = (w_wr && (w_reg == REG_IRQ_ST))
                    ? N_IN'(apb.in_pwdata & byte_mask(apb.in_pstrb)) : '0;
    // Address bits outside [4:2] and pprot carry no meaning here
    assign w_unused = ^{apb.in_pprot, apb.in_paddr[31:5], apb.in_paddr[1:0]};

    // Writable registers take strobed bytes on the access-cycle edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out    <= '0;
            r_seg    <= '1;
            r_segen  <= '1;
            r_irq_en <= '0;
        end else if (w_wr) begin
            case (w_reg)
                REG_OUT:    r_out    <= N_OUT'(strb_merge(32'(r_out), apb.in_pwdata, apb.in_pstrb));
                REG_SEG:    r_seg    <= SEG_W'(strb_merge(32'(r_seg), apb.in_pwdata, apb.in_pstrb));
                REG_SEGEN:  r_segen  <= N_DIGITS'(strb_merge(32'(r_segen), apb.in_pwdata, apb.in_pstrb));
                REG_IRQ_EN: r_irq_en <= N_IN'(strb_merge(32'(r_irq_en), apb.in_pwdata, apb.in_pstrb));
                default:    ;
            endcase
        end
    end

    // Two-flop synchroniser, edge-detect flop and sticky interrupt status
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
            r_irq_st <= '0;
        end else begin
            r_sync1  <= gpio_in;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            // Set is OR-ed after the clear so a same-cycle edge survives W1C
            r_irq_st <= (r_irq_st & ~w_w1c) | w_rise;
        end
    end

    // Read data is driven only during a mapped read access
    always_comb begin
        // NOTE: default assignment first so no path leaves w_rdata unassigned (no latch)
        w_rdata = '0;
        if (w_rd) begin
            case (w_reg)
                REG_OUT:    w_rdata = 32'(r_out);
                REG_IN:     w_rdata = 32'(r_sync2);
                REG_SEG:    w_rdata = 32'(r_seg);
                REG_SEGEN:  w_rdata = 32'(r_segen);
                REG_IRQ_EN: w_rdata = 32'(r_irq_en);
                REG_IRQ_ST: w_rdata = 32'(r_irq_st);
                default:    w_rdata = '0;
            endcase
        end
    end

    assign apb.in_prdata  = w_rdata;
    assign apb.in_pready  = w_access;
    assign apb.in_pslverr = w_access & ~w_mapped;
    assign gpio_out       = r_out;
    assign irq            = |(r_irq_st & r_irq_en);

    gpio_seg_scan #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clock     (clock),
        .reset     (reset),
        .i_seg     (r_seg),
        .i_segen   (r_segen),
        .o_seg_out (seg_out),
        .o_seg_an  (seg_an)
    );
endmodule

// File: tb/tb_gpio_seg_apb.sv
// Scoreboard bench for gpio_seg_apb: stimulus pushes expected responses into
// queues, a negedge monitor pops and compares them against the DUT.
module tb_gpio_seg_apb;
    localparam int N_OUT    = 16;
    localparam int N_IN     = 16;
    localparam int N_DIGITS = 8;
    localparam int SCAN_DIV = 4;
    localparam logic [31:0] OUT_MASK = 32'((64'd1 << N_OUT) - 64'd1);
    localparam logic [31:0] IN_MASK  = 32'((64'd1 << N_IN) - 64'd1);
    localparam logic [31:0] SEG_MASK = 32'((64'd1 << (4 * N_DIGITS)) - 64'd1);
    localparam logic [31:0] DIG_MASK = 32'((64'd1 << N_DIGITS) - 64'd1);

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [N_OUT-1:0]    gpio_out;
    logic [N_IN-1:0]     gpio_in;
    logic [7:0]          seg_out;
    logic [N_DIGITS-1:0] seg_an;
    logic                irq;

    gpio_seg_apb_if bus ();

    gpio_seg_apb #(
        .N_OUT    (N_OUT),
        .N_IN     (N_IN),
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .apb      (bus),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .seg_out  (seg_out),
        .seg_an   (seg_an),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    typedef enum {P_OUT, P_IRQ, P_SEG_OUT, P_SEG_AN} pin_e;
    typedef struct { string name; pin_e sel; logic [31:0] exp; } pin_exp_t;
    typedef struct { string name; logic [31:0] rdata; logic err; } apb_exp_t;

    pin_exp_t pin_q[$];
    apb_exp_t apb_q[$];
    pin_exp_t mon_pin;
    apb_exp_t mon_apb;
    logic [31:0] mon_act;
    int   n_vec = 0;
    int   n_mis = 0;
    int   n_cyc;
    logic done = 1'b0;
    logic done_seen = 1'b0;

    // Reference model state
    logic [31:0] m_out, m_seg, m_segen, m_irq_en, m_st, m_pins;
    logic [7:0]  glyph [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    // Clock edges since reset release: the scan position follows from this
    always @(posedge clock or negedge reset) begin
        if (!reset) n_cyc <= 0;
        else        n_cyc <= n_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: compare every APB access phase and every queued pin expectation
    always @(negedge clock) begin
        if (bus.in_psel && bus.in_penable) begin
            if (apb_q.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL apb_unexpected: access to %h with no expectation queued", bus.in_paddr);
            end else begin
                mon_apb = apb_q.pop_front();
                check({mon_apb.name, ".prdata"}, bus.in_prdata, mon_apb.rdata);
                check({mon_apb.name, ".pslverr"}, 32'(bus.in_pslverr), 32'(mon_apb.err));
                check({mon_apb.name, ".pready"}, 32'(bus.in_pready), 32'd1);
            end
        end
        while (pin_q.size() > 0) begin
            mon_pin = pin_q.pop_front();
            case (mon_pin.sel)
                P_OUT:     mon_act = 32'(gpio_out);
                P_IRQ:     mon_act = 32'(irq);
                P_SEG_OUT: mon_act = 32'(seg_out);
                default:   mon_act = 32'(seg_an);
            endcase
            check(mon_pin.name, mon_act, mon_pin.exp);
        end
        if (done && !done_seen) begin
            done_seen = 1'b1;
            check("leftover_apb", 32'(apb_q.size()), 32'd0);
            check("leftover_pin", 32'(pin_q.size()), 32'd0);
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] wdata,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        return res;
    endfunction

    function automatic logic [31:0] model_read(input int r);
        case (r)
            0:       return m_out;
            1:       return m_pins;
            2:       return m_seg;
            3:       return m_segen;
            4:       return m_irq_en;
            5:       return m_st;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_out = 0; m_seg = SEG_MASK; m_segen = DIG_MASK; m_irq_en = 0; m_st = 0; m_pins = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_pin(input string name, input pin_e sel, input logic [31:0] v);
        pin_exp_t p;
        p.name = name; p.sel = sel; p.exp = v;
        pin_q.push_back(p);
    endtask

    // Expected gpio_out, irq and the digit currently on the display
    task automatic expect_outputs(input string tag);
        int idx;
        idx = (n_cyc / SCAN_DIV) % N_DIGITS;
        expect_pin({tag, ".gpio_out"}, P_OUT, m_out);
        expect_pin({tag, ".irq"}, P_IRQ, 32'(|(m_st & m_irq_en)));
        expect_pin({tag, ".seg_an"}, P_SEG_AN, ~(32'd1 << idx) & DIG_MASK);
        expect_pin({tag, ".seg_out"}, P_SEG_OUT,
                   m_segen[idx] ? 32'(glyph[m_seg[4*idx +: 4]]) : 32'h0000_00FF);
    endtask

    task automatic apb(input string name, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wdata, input logic [3:0] strb);
        int r;
        apb_exp_t e;
        r = int'(addr[4:2]);
        e.name = name;
        e.err = (r > 5);
        e.rdata = (wr || r > 5) ? 32'd0 : model_read(r);
        @(posedge clock);
        #1;
        bus.in_psel = 1'b1; bus.in_penable = 1'b0; bus.in_paddr = addr; bus.in_pwrite = wr;
        bus.in_pwdata = wdata; bus.in_pstrb = strb; bus.in_pprot = 3'($urandom());
        @(posedge clock);
        #1;
        bus.in_penable = 1'b1;
        apb_q.push_back(e);
        @(posedge clock);
        #1;
        bus.in_psel = 1'b0; bus.in_penable = 1'b0;
        if (wr) begin
            case (r)
                0:       m_out    = merge(m_out, wdata, strb) & OUT_MASK;
                2:       m_seg    = merge(m_seg, wdata, strb) & SEG_MASK;
                3:       m_segen  = merge(m_segen, wdata, strb) & DIG_MASK;
                4:       m_irq_en = merge(m_irq_en, wdata, strb) & IN_MASK;
                5:       m_st     = m_st & ~merge(32'd0, wdata, strb);
                default: ;
            endcase
        end
    endtask

    // Drive pins; the model sees them at once and records rising edges
    task automatic set_pins(input logic [31:0] v, input logic settle);
        gpio_in = N_IN'(v);
        m_st    = m_st | (v & IN_MASK & ~m_pins);
        m_pins  = v & IN_MASK;
        if (settle) repeat (4) tick();
    endtask

    int unsigned op;
    logic [31:0] ra, rd;
    logic [3:0]  rs;

    initial begin
        bus.in_psel = 0; bus.in_penable = 0; bus.in_paddr = 0; bus.in_pwrite = 0;
        bus.in_pwdata = 0; bus.in_pstrb = 0; bus.in_pprot = 0;
        gpio_in = '0;
        model_reset();
        repeat (2) tick();
        expect_outputs("in_reset");
        tick();
        reset = 1'b1;

        for (int r = 0; r < 8; r++) apb($sformatf("rst_rd%0d", r), 32'(r * 4), 1'b0, 32'd0, 4'hF);

        // Byte strobes on OUT
        apb("t1_wr_b0", 32'h00, 1'b1, 32'h0000_A5C3, 4'b0001);
        expect_outputs("t1_b0");
        apb("t1_wr_b1", 32'h00, 1'b1, 32'h0000_A5C3, 4'b0010);
        expect_outputs("t1_b1");
        apb("t1_rd", 32'h00, 1'b0, 32'd0, 4'hF);

        // Input latency, interrupt capture and W1C
        apb("t2_en", 32'h10, 1'b1, 32'h0000_0001, 4'hF);
        tick();
        set_pins(32'h8001, 1'b0);
        expect_pin("t2_irq_c0", P_IRQ, 32'd0); tick();
        expect_pin("t2_irq_c1", P_IRQ, 32'd0); tick();
        expect_pin("t2_irq_c2", P_IRQ, 32'd0); tick();
        expect_pin("t2_irq_c3", P_IRQ, 32'd1);
        apb("t2_rd_in", 32'h04, 1'b0, 32'd0, 4'hF);
        apb("t2_rd_st", 32'h14, 1'b0, 32'd0, 4'hF);
        apb("t2_w1c", 32'h14, 1'b1, 32'h0000_0001, 4'hF);
        expect_outputs("t2_after_w1c");
        apb("t2_rd_st2", 32'h14, 1'b0, 32'd0, 4'hF);
        tick();
        set_pins(32'h8101, 1'b0);
        apb("t2_in_lat2", 32'h04, 1'b0, 32'd0, 4'hF);
        repeat (3) tick();

        // Full scan over every digit, twice round
        apb("t3_seg", 32'h08, 1'b1, 32'h7654_3210, 4'hF);
        for (int c = 0; c < 2 * N_DIGITS * SCAN_DIV + 3; c++) begin
            expect_outputs("t3_scan");
            tick();
        end

        // Digit enable mask blanks all but digit 0
        apb("t4_segen", 32'h0C, 1'b1, 32'h0000_0001, 4'hF);
        apb("t4_seg", 32'h08, 1'b1, 32'h0000_00AB, 4'hF);
        for (int c = 0; c < N_DIGITS * SCAN_DIV + 2; c++) begin
            expect_outputs("t4_scan");
            tick();
        end

        // Unmapped offsets error out and change nothing
        apb("t5_wr18", 32'h18, 1'b1, 32'hFFFF_FFFF, 4'hF);
        apb("t5_rd18", 32'h18, 1'b0, 32'd0, 4'hF);
        apb("t5_wr1c", 32'h1C, 1'b1, 32'h1234_5678, 4'hF);
        for (int r = 0; r < 6; r++) apb($sformatf("t5_rd%0d", r), 32'(r * 4), 1'b0, 32'd0, 4'hF);
        expect_outputs("t5_outs");

        // Randomised mix of accesses, pin changes and output probes
        for (int k = 0; k < 250; k++) begin
            op = $urandom_range(0, 5);
            ra = ($urandom() & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            rd = $urandom();
            rs = 4'($urandom());
            case (op)
                0, 1: begin
                    apb("rnd_wr", ra, 1'b1, rd, rs);
                    expect_outputs("rnd_after_wr");
                end
                2, 3: apb("rnd_rd", ra, 1'b0, 32'd0, 4'hF);
                4:    set_pins(rd, 1'b1);
                default: begin
                    expect_outputs("rnd_probe");
                    tick();
                end
            endcase
        end

        // Edge and W1C of the same bit on the same edge: set wins
        set_pins(32'h0, 1'b1);
        apb("t6_clr_all", 32'h14, 1'b1, 32'hFFFF_FFFF, 4'hF);
        tick();
        gpio_in = N_IN'(32'h0008);
        apb("t6_w1c_b3", 32'h14, 1'b1, 32'h0000_0008, 4'hF);
        m_st   = m_st | (32'h0008 & ~m_pins);
        m_pins = 32'h0008;
        apb("t6_rd_st", 32'h14, 1'b0, 32'd0, 4'hF);

        // Reset asserted during an access phase
        apb("t7_out", 32'h00, 1'b1, 32'h0000_1234, 4'hF);
        apb("t7_en", 32'h10, 1'b1, 32'h0000_0008, 4'hF);
        set_pins(32'h00F8, 1'b1);
        expect_outputs("t7_pre_rst");
        @(posedge clock);
        #1;
        bus.in_psel = 1'b1; bus.in_penable = 1'b0; bus.in_paddr = 32'h0; bus.in_pwrite = 1'b0;
        @(posedge clock);
        #1;
        bus.in_penable = 1'b1;
        reset = 1'b0;
        #1;
        model_reset();
        begin
            apb_exp_t e;
            e.name = "t7_mid_access"; e.rdata = 32'd0; e.err = 1'b0;
            apb_q.push_back(e);
        end
        expect_outputs("t7_in_rst");
        @(posedge clock);
        #1;
        bus.in_psel = 1'b0; bus.in_penable = 1'b0;
        tick();
        reset = 1'b1;
        set_pins(32'h00F8, 1'b1);
        apb("t7_st_once", 32'h14, 1'b0, 32'd0, 4'hF);
        apb("t7_clr", 32'h14, 1'b1, 32'hFFFF_FFFF, 4'hF);
        repeat (4) tick();
        apb("t7_st_clear", 32'h14, 1'b0, 32'd0, 4'hF);
        expect_outputs("t7_end");

        done = 1'b1;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its end within the time limit");
        $fatal(1, "timeout");
    end
endmodule
